niosii_system_button_edge_pio: RTL and testbench
================================================

// Module: niosII_system_button_edge_pio
// PURPOSE
//  Parametrised Avalon-MM input PIO for push-buttons/switches: WIDTH channels, each synchronised,
//  debounced, edge-detected into a write-1-to-clear capture register, with per-bit IRQ mask.
//  Sits on the Nios II data master like the single-bit button PIOs it replaces; irq goes to the CPU.
// PARAMETERS
//  WIDTH            4      number of input channels (1..32)
//  SYNC_STAGES      2      input synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles required to accept a new level (>=1; 1 ms @ 50 MHz)
//  INVERT           1      1: channel value = ~in_port (DE2 KEYs active-low); 0: pass-through
//  EDGE_TYPE        0      0 rising, 1 falling, 2 any edge of the debounced value sets capture
//  IRQ_MODE         1      0 level: irq = |(data & mask); 1 edge: irq = |(capture & mask)
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous active-low reset
//  address    in   2      word address of register
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data
//  in_port    in   WIDTH  raw button/switch inputs (asynchronous)
//  readdata   out  32     registered read data
//  irq        out  1      interrupt request, active-high
// BEHAVIOUR
//  Register map: 0 data (RO, debounced value) | 1 reserved (reads 0, writes ignored) |
//   2 irq_mask (RW, WIDTH bits) | 3 edge_capture (RW1C). Upper 32-WIDTH bits read 0.
//  Reset (async): sync chain, stable value, counters, irq_mask, edge_capture, readdata all 0; irq 0.
//   Stable resets to 0 post-INVERT, so released buttons produce no edge at reset release.
//  Sync: raw -> INVERT -> SYNC_STAGES flops -> s[i].
//  Debounce per channel: cnt clears whenever s[i]==stable[i]; else increments; when s[i]!=stable[i]
//   and cnt==DEBOUNCE_CYCLES-1: stable[i]<=s[i], cnt<=0. A difference shorter than DEBOUNCE_CYCLES
//   cycles is discarded. cnt width = $clog2(DEBOUNCE_CYCLES+1); never wraps.
//  Edge: capture[i] set on the same clock stable[i] updates, if direction matches EDGE_TYPE.
//  Clear: write (chipselect & ~write_n & address==3) clears capture bits where writedata[i]==1.
//   Simultaneous set and clear of one bit: set wins (bit stays 1). Other bits unaffected.
//  irq_mask: written on chipselect & ~write_n & address==2 with writedata[WIDTH-1:0].
//  Read: readdata <= mux(address) every clock (independent of chipselect), 1-cycle read latency;
//   a read coincident with a clear returns the pre-clear value.
//  irq: combinational from registers per IRQ_MODE; deasserts the cycle after clear/mask write.
//  Latency: in_port step -> stable update = SYNC_STAGES + DEBOUNCE_CYCLES clocks; +1 to readdata.
//  Reset mid-debounce: counts discarded; full DEBOUNCE_CYCLES required after release.
// STRUCTURE
//  Include niosII_system_button_pio_defs.vh: register address localparams (ADDR_DATA=0,
//   ADDR_MASK=2, ADDR_EDGE=3), EDGE_RISING/FALLING/ANY, IRQ_LEVEL/IRQ_EDGE codes.
//  Sub-module niosII_system_button_debounce (one channel: sync chain, counter, stable, rise/fall
//   pulses), instantiated WIDTH times via generate; top holds registers, read mux, irq.
// TESTING (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, INVERT=0, EDGE_TYPE=0, IRQ_MODE=1)
//  Glitch: in_port[0]=1 for 5 clk then 0 -> data reads 0x0, capture 0x0, irq 0 throughout.
//  Press: in_port[1]=1 held 20 clk, mask=0x2 -> data 0x2 after 10 clk; capture 0x2; irq=1.
//  W1C: write 0x2 to addr 3 -> capture 0x0, irq 0 next clk; write 0x0 to addr 3 -> no change.
//  Collision: W1C of bit1 on same clk as new rising edge of bit1 -> capture bit1 remains 1.
//  Reset: reset_n=0 at cnt=5 of a press -> all regs/irq 0; after release data changes 10 clk later.
//  IRQ_MODE=0, EDGE_TYPE=2: mask 0x1, hold bit0 -> irq tracks data[0]; capture sets on press and release.

Source files
------------

// File: rtl/niosii_system_button_edge_pio_pkg.sv
// Shared definitions for the button/switch edge-capture PIO: register map,
// edge-select and irq-mode codes, and small elaboration-time helpers.
package niosii_system_button_edge_pio_pkg;

    // Avalon word addresses of the four register slots
    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,   // debounced input value, read-only
        ADDR_RSVD = 2'd1,   // reads zero, writes ignored
        ADDR_MASK = 2'd2,   // per-channel irq mask
        ADDR_EDGE = 2'd3    // edge capture, write-1-to-clear
    } reg_addr_e;

    // Which transitions of the debounced value set a capture bit
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Interrupt source selection
    localparam int IRQ_LEVEL = 0;   // irq follows masked debounced data
    localparam int IRQ_EDGE  = 1;   // irq follows masked capture register

    // Bus data width of the Avalon slave
    localparam int BUS_W = 32;

    // Counter width able to hold 0..cycles without wrapping
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // True when a debounced transition matches the selected edge type
    function automatic logic edge_hit(input int edge_type, input logic rise, input logic fall);
        logic hit;
        case (edge_type)
            EDGE_RISING:  hit = rise;
            EDGE_FALLING: hit = fall;
            default:      hit = rise | fall;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/niosii_system_button_edge_pio_debounce.sv
// One input channel: optional inversion, synchroniser chain, stability counter
// and debounced level, plus single-cycle rise/fall strobes that fire on the
// very clock the debounced level changes.
module niosii_system_button_edge_pio_debounce
    import niosii_system_button_edge_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int INVERT          = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                   in_bit;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   stable_reg;
    logic                   stable_next;
    logic                   accept;

    // Polarity is applied before synchronising, so a reset chain of zeros
    // matches a released active-low button and no edge appears at reset exit.
    assign in_bit = (INVERT != 0) ? ~raw : raw;

    // Shift the asynchronous input through the metastability chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign sync_bit = sync_reg[SYNC_STAGES-1];

    // A new level is accepted on the cycle the difference has persisted
    // for the full debounce window.
    assign accept = (sync_bit != stable_reg) && (cnt_reg == CNT_LAST);

    // Next-state for the stability counter and debounced level
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        if (sync_bit == stable_reg) begin
            cnt_next = '0;
        end else if (accept) begin
            stable_next = sync_bit;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Register the counter and debounced level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
        end
    end

    assign stable = stable_reg;
    assign rise   = accept & sync_bit;
    assign fall   = accept & ~sync_bit;

endmodule

// File: rtl/niosii_system_button_edge_pio.sv
// Avalon-MM input PIO for push-buttons and switches. Each channel is
// synchronised and debounced; selected transitions of the debounced value are
// latched into a write-1-to-clear capture register, and a per-channel mask
// gates either the capture bits or the live data onto irq.
module niosii_system_button_edge_pio
    import niosii_system_button_edge_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int INVERT          = 1,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] data_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] set_w;

    logic             wr_en;
    logic             mask_wr;
    logic             edge_wr;
    logic [WIDTH-1:0] clear_w;

    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] irq_mask_next;
    logic [WIDTH-1:0] capture_reg;
    logic [WIDTH-1:0] capture_next;
    logic [BUS_W-1:0] readdata_reg;
    logic [BUS_W-1:0] readdata_next;

    // Only the low WIDTH bits of a write carry meaning; the rest are dropped.
    logic unused_wd;
    assign unused_wd = ^writedata;

    // One debouncer per channel, each raising its own capture request
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            niosii_system_button_edge_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INVERT          (INVERT)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .raw     (in_port[gi]),
                .stable  (data_w[gi]),
                .rise    (rise_w[gi]),
                .fall    (fall_w[gi])
            );

            assign set_w[gi] = edge_hit(EDGE_TYPE, rise_w[gi], fall_w[gi]);
        end
    endgenerate

    // Bus write decode
    assign wr_en   = chipselect & ~write_n;
    assign mask_wr = wr_en && (address == ADDR_MASK);
    assign edge_wr = wr_en && (address == ADDR_EDGE);
    assign clear_w = edge_wr ? writedata[WIDTH-1:0] : '0;

    // Register next-state: a new edge beats a coincident clear of the same bit
    always_comb begin
        irq_mask_next = irq_mask_reg;
        if (mask_wr) begin
            irq_mask_next = writedata[WIDTH-1:0];
        end
        capture_next = (capture_reg & ~clear_w) | set_w;
    end

    // Read mux runs every clock from pre-update register values, so a read
    // that coincides with a clear returns what was cleared.
    always_comb begin
        readdata_next = '0;
        case (reg_addr_e'(address))
            ADDR_DATA: readdata_next[WIDTH-1:0] = data_w;
            ADDR_MASK: readdata_next[WIDTH-1:0] = irq_mask_reg;
            ADDR_EDGE: readdata_next[WIDTH-1:0] = capture_reg;
            default:   readdata_next = '0;
        endcase
    end

    // Mask, capture and read-data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_reg <= '0;
            capture_reg  <= '0;
            readdata_reg <= '0;
        end else begin
            irq_mask_reg <= irq_mask_next;
            capture_reg  <= capture_next;
            readdata_reg <= readdata_next;
        end
    end

    assign readdata = readdata_reg;

    // Interrupt is a pure function of registered state
    assign irq = (IRQ_MODE == IRQ_EDGE) ? |(capture_reg & irq_mask_reg)
                                        : |(data_w & irq_mask_reg);

endmodule

// File: tb/tb_niosii_system_button_edge_pio.sv
// Scoreboard bench: stimulus pushes expected read data / irq levels into
// queues, an independent monitor pops and compares them as the DUTs respond.
// DUT A: rising-edge capture, edge irq. DUT B: any-edge capture, level irq.
module tb_niosii_system_button_edge_pio;

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port_a;
    logic [3:0]  in_port_b;
    logic [31:0] readdata_a;
    logic [31:0] readdata_b;
    logic        irq_a;
    logic        irq_b;

    exp_t rd_q[$];
    exp_t irq_q[$];
    logic rd_req   = 1'b0;
    logic rd_stage = 1'b0;
    int   irq_req_cnt  = 0;
    int   irq_seen_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    niosii_system_button_edge_pio #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
        .INVERT(0), .EDGE_TYPE(0), .IRQ_MODE(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_a),
        .readdata(readdata_a), .irq(irq_a)
    );

    niosii_system_button_edge_pio #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
        .INVERT(0), .EDGE_TYPE(2), .IRQ_MODE(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    // ---------------- monitor ----------------
    always @(posedge clk) rd_stage <= rd_req;

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] act;
        if (rd_stage) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_underflow: got read data with no expectation queued");
            end else begin
                e   = rd_q.pop_front();
                act = (e.dut == 0) ? readdata_a : readdata_b;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d: readdata got 0x%08h expected 0x%08h", e.name, e.dut, act, e.exp);
                end else begin
                    $display("check %s dut%0d readdata 0x%08h ok", e.name, e.dut, act);
                end
            end
        end
        while (irq_seen_cnt < irq_req_cnt) begin
            irq_seen_cnt++;
            checks++;
            if (irq_q.size() == 0) begin
                failures++;
                $display("FAIL irq_underflow: irq check with no expectation queued");
            end else begin
                e      = irq_q.pop_front();
                act    = '0;
                act[0] = (e.dut == 0) ? irq_a : irq_b;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d: irq got %0d expected %0d", e.name, e.dut, act[0], e.exp[0]);
                end else begin
                    $display("check %s dut%0d irq %0d ok", e.name, e.dut, act[0]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bus write lasting one clock
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Read: readdata registered at the next edge, checked by the monitor
    task automatic rd(input int dut, input logic [1:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        x.name = nm; x.dut = dut; x.exp = e;
        rd_q.push_back(x);
        address = a; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    // Write that also samples readdata in the same cycle
    task automatic wr_rd(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e, input string nm);
        exp_t x;
        x.name = nm; x.dut = 0; x.exp = e;
        rd_q.push_back(x);
        rd_req = 1'b1;
        wr(a, d);
        rd_req = 1'b0;
    endtask

    // Check irq level in the current cycle (no time consumed)
    task automatic chk_irq(input int dut, input logic e, input string nm);
        exp_t x;
        x.name = nm; x.dut = dut; x.exp = {31'd0, e};
        irq_q.push_back(x);
        irq_req_cnt++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port_a = '0; in_port_b = '0;
        ticks(2);

        // Reset state
        chk_irq(0, 1'b0, "reset_irq_a");
        chk_irq(1, 1'b0, "reset_irq_b");
        rd(0, 2'd0, 32'h0, "reset_data");
        rd(0, 2'd3, 32'h0, "reset_edge");
        reset_n = 1'b1;
        ticks(2);
        rd(0, 2'd2, 32'h0, "reset_mask");

        // Mask width, reserved slot
        wr(2'd2, 32'hFFFF_FFFF);
        rd(0, 2'd2, 32'h0000_000F, "mask_upper_zero");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(0, 2'd1, 32'h0, "reserved_reads_zero");
        wr(2'd2, 32'h3);

        // Glitch shorter than the debounce window is ignored
        in_port_a[0] = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 5) in_port_a[0] = 1'b0;
            chk_irq(0, 1'b0, "glitch_irq");
            rd(0, 2'd0, 32'h0, "glitch_data");
        end
        rd(0, 2'd3, 32'h0, "glitch_edge");

        // Press bit1: stable after SYNC_STAGES + DEBOUNCE_CYCLES = 10 clocks
        wr(2'd2, 32'h2);
        in_port_a[1] = 1'b1;
        ticks(9);
        chk_irq(0, 1'b0, "press_irq_before");
        rd(0, 2'd0, 32'h0, "press_data_before");
        chk_irq(0, 1'b1, "press_irq_after");
        rd(0, 2'd0, 32'h2, "press_data_after");
        rd(0, 2'd3, 32'h2, "press_edge");
        ticks(8);
        in_port_a[1] = 1'b0;
        ticks(12);
        rd(0, 2'd0, 32'h0, "release_data");
        rd(0, 2'd3, 32'h2, "release_edge_kept");
        chk_irq(0, 1'b1, "release_irq_kept");

        // Write-1-to-clear
        wr(2'd3, 32'h2);
        chk_irq(0, 1'b0, "w1c_irq");
        rd(0, 2'd3, 32'h0, "w1c_edge");

        // Clear coincident with a new rising edge: set wins
        in_port_a[1] = 1'b1;
        ticks(9);
        wr(2'd3, 32'h2);
        chk_irq(0, 1'b1, "collide_irq");
        rd(0, 2'd3, 32'h2, "collide_edge");
        rd(0, 2'd0, 32'h2, "collide_data");
        wr(2'd3, 32'h0);
        rd(0, 2'd3, 32'h2, "w1c_zero_nochange");
        wr(2'd3, 32'h1);
        rd(0, 2'd3, 32'h2, "w1c_other_bit");
        chk_irq(0, 1'b1, "w1c_other_irq");

        // Reset in the middle of a bit2 debounce (cnt == 5)
        in_port_a[2] = 1'b1;
        ticks(7);
        reset_n = 1'b0;
        chk_irq(0, 1'b0, "midreset_irq");
        rd(0, 2'd0, 32'h0, "midreset_data");
        rd(0, 2'd3, 32'h0, "midreset_edge");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) rd(0, 2'd0, 32'h0, "postreset_data_wait");
        rd(0, 2'd0, 32'h6, "postreset_data");
        rd(0, 2'd3, 32'h6, "postreset_edge");
        rd(0, 2'd2, 32'h0, "postreset_mask");
        chk_irq(0, 1'b0, "postreset_irq");

        // Read coincident with clear returns the pre-clear value
        wr_rd(2'd3, 32'h4, 32'h6, "read_during_clear");
        rd(0, 2'd3, 32'h2, "after_clear_edge");
        in_port_a = '0;

        // DUT B: level irq tracks data[0]; capture on press and release
        wr(2'd2, 32'h1);
        in_port_b[0] = 1'b1;
        ticks(9);
        chk_irq(1, 1'b0, "lvl_irq_before");
        tick();
        chk_irq(1, 1'b1, "lvl_irq_press");
        rd(1, 2'd3, 32'h1, "any_edge_press");
        rd(1, 2'd0, 32'h1, "lvl_data_press");
        wr(2'd3, 32'h1);
        rd(1, 2'd3, 32'h0, "any_edge_cleared");
        chk_irq(1, 1'b1, "lvl_irq_after_clear");
        in_port_b[0] = 1'b0;
        ticks(9);
        chk_irq(1, 1'b1, "lvl_irq_hold");
        tick();
        chk_irq(1, 1'b0, "lvl_irq_release");
        rd(1, 2'd3, 32'h1, "any_edge_release");
        rd(1, 2'd0, 32'h0, "lvl_data_release");

        ticks(3);
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d reads and %0d irq checks left, expected 0 and 0",
                     rd_q.size(), irq_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
